// File: rtl/npu_pkg.sv
// Shared NPU encodings: sigmoid function selects, result destinations and the
// in-flight tracker entry used by the sigmoid scheduler.
package npu_pkg;

  typedef enum logic [1:0] {
    SIG_FN_SIGMOID = 2'd0,
    SIG_FN_TANH    = 2'd1,
    SIG_FN_LINEAR  = 2'd2,
    SIG_FN_STEP    = 2'd3
  } sig_fn_e;

  typedef enum logic {
    DEST_SIG_FIFO = 1'b0,
    DEST_OUT_FIFO = 1'b1
  } dest_e;

  typedef struct packed {
    logic  valid;
    dest_e dest;
  } inflight_t;

endpackage

// File: rtl/npu_sigmoid_scheduler_if.sv
// PE-array / FIFO side bundle of the sigmoid scheduler. The slave modport is
// the scheduler; the master modport is the PE array and FIFO status side.
interface npu_sigmoid_scheduler_if #(
  parameter int unsigned NUM_PE   = 8,
  parameter int unsigned PE_IDX_W = 3
);
  logic [NUM_PE-1:0]   pe_req;
  logic [2*NUM_PE-1:0] pe_func_sel;
  logic [NUM_PE-1:0]   pe_to_output;
  logic [NUM_PE-1:0]   pe_grant;
  logic [PE_IDX_W-1:0] npu_sched_din_sel;
  logic                npu_sched_sigmoid_input_en;
  logic [1:0]          npu_sched_sigmoid_function_sel;
  logic                sig_fifo_afull;
  logic                out_fifo_afull;
  logic                sig_fifo_wr_en;
  logic                out_fifo_wr_en;
  logic                sched_busy;

  modport slave (
    input  pe_req, pe_func_sel, pe_to_output, sig_fifo_afull, out_fifo_afull,
    output pe_grant, npu_sched_din_sel, npu_sched_sigmoid_input_en,
           npu_sched_sigmoid_function_sel, sig_fifo_wr_en, out_fifo_wr_en, sched_busy
  );

  modport master (
    output pe_req, pe_func_sel, pe_to_output, sig_fifo_afull, out_fifo_afull,
    input  pe_grant, npu_sched_din_sel, npu_sched_sigmoid_input_en,
           npu_sched_sigmoid_function_sel, sig_fifo_wr_en, out_fifo_wr_en, sched_busy
  );
endinterface

// File: rtl/npu_rr_arbiter.sv
// Round-robin arbiter over NUM_PE requesters with a combinational one-hot grant.
// Defining NPU_SCHED_FIXED_PRIORITY_EN selects lowest-index-wins and drops the pointer.
module npu_rr_arbiter #(
  parameter int unsigned NUM_PE   = 8,
  parameter int unsigned PE_IDX_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_PE-1:0]   req,
  input  logic [NUM_PE-1:0]   mask,
  output logic [NUM_PE-1:0]   grant,
  output logic [PE_IDX_W-1:0] grant_idx,
  output logic                grant_vld
);
  logic [NUM_PE-1:0] elig;

  assign elig = req & ~mask;

`ifdef NPU_SCHED_FIXED_PRIORITY_EN
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      if (!grant_vld && elig[i]) begin
        grant[i]  = 1'b1;
        grant_idx = PE_IDX_W'(i);
        grant_vld = 1'b1;
      end
    end
  end
`else
  logic [PE_IDX_W-1:0] ptr;
  logic [PE_IDX_W:0]   sum;
  logic [PE_IDX_W-1:0] idx;

  // Search ptr, ptr+1, ... with modulo wrap; first eligible candidate wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_PE; k++) begin
      sum = {1'b0, ptr} + (PE_IDX_W+1)'(k);
      if (sum >= (PE_IDX_W+1)'(NUM_PE)) sum = sum - (PE_IDX_W+1)'(NUM_PE);
      idx = sum[PE_IDX_W-1:0];
      if (!grant_vld && elig[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_vld  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_vld) begin
      ptr <= (grant_idx == PE_IDX_W'(NUM_PE-1)) ? '0 : grant_idx + PE_IDX_W'(1);
    end
  end
`endif

endmodule

// File: rtl/npu_sigmoid_scheduler.sv
// Issues completed PE results to the shared sigmoid unit and steers each result
// to its destination FIFO when it leaves the SIG_LATENCY-deep sigmoid pipeline.
module npu_sigmoid_scheduler
  import npu_pkg::*;
#(
  parameter int unsigned NUM_PE      = 8,
  parameter int unsigned PE_IDX_W    = 3,
  parameter int unsigned SIG_LATENCY = 3
) (
  input  logic                     CLK,
  input  logic                     npu_rst,
  npu_sigmoid_scheduler_if.slave   sif
);
  logic [NUM_PE-1:0]   blocked;
  logic [NUM_PE-1:0]   arb_mask;
  logic [NUM_PE-1:0]   grant;
  logic [PE_IDX_W-1:0] grant_idx;
  logic                grant_vld;
  logic [1:0]          issue_fn;
  dest_e               issue_dest;

  logic [NUM_PE-1:0]   grant_q;
  logic [PE_IDX_W-1:0] din_sel_q;
  logic                input_en_q;
  logic [1:0]          func_q;
  dest_e               dest_q;
  inflight_t           trk [SIG_LATENCY];
  logic                trk_any;

  always_comb begin
    blocked    = '0;
    issue_fn   = '0;
    issue_dest = DEST_SIG_FIFO;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      blocked[i] = sif.pe_to_output[i] ? sif.out_fifo_afull : sif.sig_fifo_afull;
      if (grant[i]) begin
        issue_fn   = sif.pe_func_sel[2*i +: 2];
        issue_dest = dest_e'(sif.pe_to_output[i]);
      end
    end
  end

  // Last cycle's grantee is masked while its level request falls.
  assign arb_mask = grant_q | blocked;

  npu_rr_arbiter #(
    .NUM_PE   (NUM_PE),
    .PE_IDX_W (PE_IDX_W)
  ) u_arb (
    .clk       (CLK),
    .rst       (npu_rst),
    .req       (sif.pe_req),
    .mask      (arb_mask),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Tracker stage 0 is loaded from the registered issue, so stage SIG_LATENCY-1
  // lines up with the cycle the sigmoid result is valid.
  always_ff @(posedge CLK or posedge npu_rst) begin
    if (npu_rst) begin
      grant_q    <= '0;
      din_sel_q  <= '0;
      input_en_q <= 1'b0;
      func_q     <= '0;
      dest_q     <= DEST_SIG_FIFO;
      for (int unsigned k = 0; k < SIG_LATENCY; k++) trk[k] <= '0;
    end else begin
      grant_q    <= grant;
      input_en_q <= grant_vld;
      if (grant_vld) begin
        din_sel_q <= grant_idx;
        func_q    <= issue_fn;
        dest_q    <= issue_dest;
      end
      trk[0] <= '{valid: input_en_q, dest: dest_q};
      for (int unsigned k = 1; k < SIG_LATENCY; k++) trk[k] <= trk[k-1];
    end
  end

  always_comb begin
    trk_any = 1'b0;
    for (int unsigned k = 0; k < SIG_LATENCY; k++) trk_any = trk_any | trk[k].valid;
  end

  assign sif.pe_grant                       = grant_q;
  assign sif.npu_sched_din_sel              = din_sel_q;
  assign sif.npu_sched_sigmoid_input_en     = input_en_q;
  assign sif.npu_sched_sigmoid_function_sel = func_q;
  assign sif.sig_fifo_wr_en = trk[SIG_LATENCY-1].valid && (trk[SIG_LATENCY-1].dest == DEST_SIG_FIFO);
  assign sif.out_fifo_wr_en = trk[SIG_LATENCY-1].valid && (trk[SIG_LATENCY-1].dest == DEST_OUT_FIFO);
  assign sif.sched_busy     = (|sif.pe_req) | trk_any | input_en_q;

endmodule

// File: tb/tb_npu_sigmoid_scheduler.sv
// Directed bench for npu_sigmoid_scheduler (NUM_PE=8, SIG_LATENCY=3): issue,
// fairness, backpressure, pointer wrap, re-request spacing and mid-flight reset.
module tb_npu_sigmoid_scheduler;
  logic clk;
  logic rst;
  int unsigned checks;
  int unsigned failures;
  int unsigned wr_seen;

  npu_sigmoid_scheduler_if #(.NUM_PE(8), .PE_IDX_W(3)) sif ();

  npu_sigmoid_scheduler #(
    .NUM_PE      (8),
    .PE_IDX_W    (3),
    .SIG_LATENCY (3)
  ) dut (
    .CLK     (clk),
    .npu_rst (rst),
    .sif     (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(sif.pe_grant), 0);
    chk({tag, "_en"},    32'(sif.npu_sched_sigmoid_input_en), 0);
    chk({tag, "_din"},   32'(sif.npu_sched_din_sel), 0);
    chk({tag, "_fn"},    32'(sif.npu_sched_sigmoid_function_sel), 0);
    chk({tag, "_swr"},   32'(sif.sig_fifo_wr_en), 0);
    chk({tag, "_owr"},   32'(sif.out_fifo_wr_en), 0);
    chk({tag, "_busy"},  32'(sif.sched_busy), 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    sif.pe_req         = '0;
    sif.pe_func_sel    = '0;
    sif.pe_to_output   = '0;
    sif.sig_fifo_afull = 1'b0;
    sif.out_fifo_afull = 1'b0;
    repeat (2) cyc();
    chk_all_zero("rst");
    rst = 1'b0;
    cyc();

    // Single request from PE2, tanh, to sigmoid FIFO
    sif.pe_func_sel = 16'h0010;
    sif.pe_req      = 8'h04;
    cyc();
    chk("t1_grant", 32'(sif.pe_grant), 32'h04);
    chk("t1_din",   32'(sif.npu_sched_din_sel), 2);
    chk("t1_fn",    32'(sif.npu_sched_sigmoid_function_sel), 1);
    chk("t1_en",    32'(sif.npu_sched_sigmoid_input_en), 1);
    sif.pe_req = '0;
    cyc();
    chk("t1_en_off",  32'(sif.npu_sched_sigmoid_input_en), 0);
    chk("t1_din_hold", 32'(sif.npu_sched_din_sel), 2);
    chk("t1_fn_hold", 32'(sif.npu_sched_sigmoid_function_sel), 1);
    chk("t1_swr_early", 32'(sif.sig_fifo_wr_en), 0);
    cyc();
    chk("t1_swr_early2", 32'(sif.sig_fifo_wr_en), 0);
    cyc();
    chk("t1_swr", 32'(sif.sig_fifo_wr_en), 1);
    chk("t1_owr", 32'(sif.out_fifo_wr_en), 0);
    chk("t1_busy", 32'(sif.sched_busy), 1);
    cyc();
    chk("t1_swr_off", 32'(sif.sig_fifo_wr_en), 0);
    chk("t1_idle", 32'(sif.sched_busy), 0);

    // All-request fairness from a reset pointer
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sif.pe_func_sel = '0;
    sif.pe_req      = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk($sformatf("t2_grant%0d", k), 32'(sif.pe_grant), 32'(1) << k);
      sif.pe_req[k] = 1'b0;
    end
    repeat (3) cyc();
    chk("t2_last_swr", 32'(sif.sig_fifo_wr_en), 1);
    chk("t2_last_busy", 32'(sif.sched_busy), 1);
    cyc();
    chk("t2_busy_fall", 32'(sif.sched_busy), 0);

    // Backpressure: PE3 to full output FIFO, PE5 to sigmoid FIFO
    sif.pe_to_output   = 8'h08;
    sif.out_fifo_afull = 1'b1;
    sif.pe_req         = 8'h28;
    cyc();
    chk("t3_grant5", 32'(sif.pe_grant), 32'h20);
    sif.pe_req = 8'h08;
    cyc();
    chk("t3_blocked", 32'(sif.pe_grant), 0);
    sif.out_fifo_afull = 1'b0;
    cyc();
    chk("t3_grant3", 32'(sif.pe_grant), 32'h08);
    chk("t3_din", 32'(sif.npu_sched_din_sel), 3);
    sif.pe_req = '0;
    repeat (3) cyc();
    chk("t3_owr", 32'(sif.out_fifo_wr_en), 1);
    chk("t3_swr", 32'(sif.sig_fifo_wr_en), 0);
    sif.pe_to_output = '0;

    // Wrap-around: grant 6 sets ptr=7, then PE7 precedes PE0
    sif.pe_req = 8'h40;
    cyc();
    chk("t4_grant6", 32'(sif.pe_grant), 32'h40);
    sif.pe_func_sel = 16'hC002;
    sif.pe_req      = 8'h81;
    cyc();
    chk("t4_grant7", 32'(sif.pe_grant), 32'h80);
    chk("t4_din7", 32'(sif.npu_sched_din_sel), 7);
    chk("t4_fn7", 32'(sif.npu_sched_sigmoid_function_sel), 3);
    sif.pe_req = 8'h01;
    cyc();
    chk("t4_grant0", 32'(sif.pe_grant), 32'h01);
    chk("t4_din0", 32'(sif.npu_sched_din_sel), 0);
    chk("t4_fn0", 32'(sif.npu_sched_sigmoid_function_sel), 2);

    // Lone PE1 holding its request issues every other cycle
    sif.pe_req = 8'h02;
    cyc();
    chk("t5_g0", 32'(sif.pe_grant), 32'h02);
    cyc();
    chk("t5_g1", 32'(sif.pe_grant), 0);
    cyc();
    chk("t5_g2", 32'(sif.pe_grant), 32'h02);
    sif.pe_req = '0;
    repeat (5) cyc();

    // Reset while three operands are in flight
    sif.pe_func_sel  = 16'h001F;
    sif.pe_to_output = 8'h02;
    sif.pe_req       = 8'h07;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("t6_issue%0d", k), 32'(sif.npu_sched_sigmoid_input_en), 1);
      sif.pe_req = sif.pe_req & ~sif.pe_grant;
    end
    rst        = 1'b1;
    sif.pe_req = '0;
    #1;
    chk_all_zero("t6_inrst");
    cyc();
    rst = 1'b0;
    wr_seen = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (sif.sig_fifo_wr_en || sif.out_fifo_wr_en) wr_seen++;
    end
    chk("t6_no_wr", wr_seen, 0);

    // PE1 and PE6 held: PE6 only wins in PE1's masked cycles
    sif.pe_to_output = '0;
    sif.pe_func_sel  = '0;
    sif.pe_req       = 8'h42;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("t7_alt%0d", k), 32'(sif.pe_grant), (k % 2 == 0) ? 32'h02 : 32'h40);
    end
    sif.pe_req = '0;
    repeat (6) cyc();
    chk("t7_idle", 32'(sif.sched_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
